// File: rtl/change_dispenser.sv
// Change dispenser: accumulates credit, latches price and pays change greedily (500s then 100s)
// through a req/ack hopper handshake. Define EXACT_CHANGE_EN to enable the exact-change-only mode.
module change_dispenser #(
    parameter int MAX_CREDIT  = 20,
    parameter int INV500_INIT = 10,
    parameter int INV100_INIT = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_cien,
    input  logic       en_quin,
    input  logic [7:0] valor_producto,
    input  logic       vuelto,
    input  logic       coin_ack,
    input  logic       refill,
    output logic [7:0] credit,
    output logic       credit_ok,
    output logic       busy,
    output logic       pay_500,
    output logic       pay_100,
    output logic       coin_reject,
    output logic       done,
    output logic       short_fault,
    output logic       hopper_fault,
    output logic [7:0] inv_500,
    output logic [7:0] inv_100,
    output logic       exact_only
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PAY500, S_PAY100, S_DONE, S_SHORT
    } state_t;

    localparam logic [8:0]  MAX_C    = 9'(MAX_CREDIT);
    localparam logic [7:0]  INV5_RST = 8'(INV500_INIT);
    localparam logic [7:0]  INV1_RST = 8'(INV100_INIT);
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  credit_q, credit_d;
    logic [7:0]  price_q, price_d;
    logic [7:0]  change_q, change_d;
    logic [7:0]  inv_500_q, inv_500_d;
    logic [7:0]  inv_100_q, inv_100_d;
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic        coin_reject_q, coin_reject_d;
    logic        hopper_fault_q, hopper_fault_d;

    logic [8:0]  sum_quin, sum_cien;

    assign sum_quin = {1'b0, credit_q} + 9'd5;
    assign sum_cien = {1'b0, credit_q} + 9'd1;

`ifdef EXACT_CHANGE_EN
    assign exact_only = (inv_100_q < 8'd4);
`else
    assign exact_only = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= 8'd0;
            price_q        <= 8'd0;
            change_q       <= 8'd0;
            inv_500_q      <= INV5_RST;
            inv_100_q      <= INV1_RST;
            ack_cnt_q      <= 16'd0;
            coin_reject_q  <= 1'b0;
            hopper_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            change_q       <= change_d;
            inv_500_q      <= inv_500_d;
            inv_100_q      <= inv_100_d;
            ack_cnt_q      <= ack_cnt_d;
            coin_reject_q  <= coin_reject_d;
            hopper_fault_q <= hopper_fault_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        change_d       = change_q;
        inv_500_d      = inv_500_q;
        inv_100_d      = inv_100_q;
        ack_cnt_d      = ack_cnt_q;
        coin_reject_d  = 1'b0;
        hopper_fault_d = hopper_fault_q;

        case (state_q)
            S_IDLE: begin
                if (vuelto) begin
                    change_d = (credit_q >= price_q) ? (credit_q - price_q) : credit_q;
                    state_d  = S_CALC;
                end else begin
                    // A simultaneous 100 strobe always loses to the 500 coin.
                    if (en_quin) begin
                        if (exact_only || (sum_quin > MAX_C)) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = sum_quin[7:0];
                        end
                        if (en_cien) begin
                            coin_reject_d = 1'b1;
                        end
                    end else if (en_cien) begin
                        if (sum_cien > MAX_C) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = sum_cien[7:0];
                        end
                    end
                    if (valor_producto != 8'd0) begin
                        price_d = valor_producto;
                    end
                end
            end
            S_CALC: begin
                ack_cnt_d = 16'd0;
                if ((change_q >= 8'd5) && (inv_500_q != 8'd0)) begin
                    state_d = S_PAY500;
                end else if ((change_q != 8'd0) && (inv_100_q != 8'd0)) begin
                    state_d = S_PAY100;
                end else if (change_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHORT;
                end
            end
            S_PAY500: begin
                if (coin_ack) begin
                    if (inv_500_q != 8'd0) inv_500_d = inv_500_q - 8'd1;
                    change_d = change_q - 8'd5;
                    state_d  = S_CALC;
                end else if (ack_cnt_q == TMO_LAST) begin
                    hopper_fault_d = 1'b1;
                    state_d        = S_SHORT;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            S_PAY100: begin
                if (coin_ack) begin
                    if (inv_100_q != 8'd0) inv_100_d = inv_100_q - 8'd1;
                    change_d = change_q - 8'd1;
                    state_d  = S_CALC;
                end else if (ack_cnt_q == TMO_LAST) begin
                    hopper_fault_d = 1'b1;
                    state_d        = S_SHORT;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                credit_d = 8'd0;
                price_d  = 8'd0;
                change_d = 8'd0;
                state_d  = S_IDLE;
            end
            S_SHORT: begin
                if (refill) begin
                    hopper_fault_d = 1'b0;
                    state_d        = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reload wins over a same-cycle decrement.
        if (refill) begin
            inv_500_d = INV5_RST;
            inv_100_d = INV1_RST;
        end
    end

    assign credit       = credit_q;
    assign credit_ok    = (price_q != 8'd0) && (credit_q >= price_q);
    assign busy         = (state_q == S_CALC) || (state_q == S_PAY500) ||
                          (state_q == S_PAY100) || (state_q == S_SHORT);
    assign pay_500      = (state_q == S_PAY500);
    assign pay_100      = (state_q == S_PAY100);
    assign coin_reject  = coin_reject_q;
    assign done         = (state_q == S_DONE);
    assign short_fault  = (state_q == S_SHORT);
    assign hopper_fault = hopper_fault_q;
    assign inv_500      = inv_500_q;
    assign inv_100      = inv_100_q;

endmodule
